hbridge_deadtime_guard: RTL

//   Output-stage safety guard between the stepper drive mux and the H-bridge pins.

---
 rtl/hbridge_deadtime_guard_pkg.sv | 38 +++
 rtl/hbridge_guard_channel.sv | 98 +++++++++
 rtl/hbridge_deadtime_guard.sv | 76 +++++++
 3 files changed

// File: rtl/hbridge_deadtime_guard_pkg.sv
// =============================================================================
// Module  : hbridge_deadtime_guard_pkg
// Brief   : Shared channel-state and request encodings for the H-bridge guard.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package hbridge_deadtime_guard_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE_L = 2'd1,
        ST_DRIVE_R = 2'd2,
        ST_DEAD    = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_L   = 2'd1,
        REQ_R   = 2'd2
    } req_e;

    // State a leg settles in when it is free to follow the given request.
    function automatic chan_state_e req_target(input req_e req);
        chan_state_e st;
        case (req)
            REQ_L:   st = ST_DRIVE_L;
            REQ_R:   st = ST_DRIVE_R;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_guard_channel.sv
// =============================================================================
// Module  : hbridge_guard_channel
// Brief   : One bridge leg: request decode, drive FSM and dead-time counter.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module hbridge_guard_channel
    import hbridge_deadtime_guard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_l,
    input  logic             i_r,
    output logic             o_l,
    output logic             o_r,
    output logic             o_dead,
    output logic             o_illegal
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_e             req_w;
    logic [CNT_W-1:0] dead_len_w;

    always_comb begin
        req_w = REQ_OFF;
        if (i_enable) begin
            if (i_l && !i_r) begin
                req_w = REQ_L;
            end else if (i_r && !i_l) begin
                req_w = REQ_R;
            end
        end
    end

    assign o_illegal  = i_enable & i_l & i_r;
    // A zero period still yields a one-cycle both-off gap.
    assign dead_len_w = (i_period == '0) ? CNT_ONE : i_period;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = req_target(req_w);
            end
            ST_DRIVE_L: begin
                if (req_w != REQ_L) begin
                    state_d = ST_DEAD;
                    cnt_d   = dead_len_w;
                end
            end
            ST_DRIVE_R: begin
                if (req_w != REQ_R) begin
                    state_d = ST_DEAD;
                    cnt_d   = dead_len_w;
                end
            end
            ST_DEAD: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = req_target(req_w);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // rst is active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_l    = (state_q == ST_DRIVE_L);
    assign o_r    = (state_q == ST_DRIVE_R);
    assign o_dead = (state_q == ST_DEAD);

endmodule

`default_nettype wire

// File: rtl/hbridge_deadtime_guard.sv
// =============================================================================
// Module  : hbridge_deadtime_guard
// Brief   : Dead-time and shoot-through guard for two H-bridge output stages.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module hbridge_deadtime_guard
    import hbridge_deadtime_guard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_shoot_through_period,
    input  logic             i_hbridge0_l,
    input  logic             i_hbridge0_r,
    input  logic             i_hbridge1_l,
    input  logic             i_hbridge1_r,
    input  logic             i_clear_err,
    output logic             o_hbridge0_l,
    output logic             o_hbridge0_r,
    output logic             o_hbridge1_l,
    output logic             o_hbridge1_r,
    output logic             o_busy,
    output logic             o_err_shoot_through
);

    logic dead0_w, dead1_w;
    logic illegal0_w, illegal1_w;
    logic err_q;

    hbridge_guard_channel #(.CNT_W(CNT_W)) u_ch0 (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (i_enable),
        .i_period  (i_shoot_through_period),
        .i_l       (i_hbridge0_l),
        .i_r       (i_hbridge0_r),
        .o_l       (o_hbridge0_l),
        .o_r       (o_hbridge0_r),
        .o_dead    (dead0_w),
        .o_illegal (illegal0_w)
    );

    hbridge_guard_channel #(.CNT_W(CNT_W)) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (i_enable),
        .i_period  (i_shoot_through_period),
        .i_l       (i_hbridge1_l),
        .i_r       (i_hbridge1_r),
        .o_l       (o_hbridge1_l),
        .o_r       (o_hbridge1_r),
        .o_dead    (dead1_w),
        .o_illegal (illegal1_w)
    );

    // A new violation outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (illegal0_w || illegal1_w) begin
            err_q <= 1'b1;
        end else if (i_clear_err) begin
            err_q <= 1'b0;
        end
    end

    assign o_err_shoot_through = err_q;
    assign o_busy              = dead0_w | dead1_w;

endmodule

`default_nettype wire
